// File: rtl/hack_cpu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hack_cpu_seq
//  Description : Multi-cycle Hack sequencer: fetch, decode, data-memory access
//                and jump control around an external combinational ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_cpu_seq #(
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            rom_req,
    output logic [PC_W-1:0] rom_addr,
    input  logic [15:0]     rom_rdata,
    input  logic            rom_ack,
    output logic            mem_re,
    output logic            mem_we,
    output logic [PC_W-1:0] mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ack,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic            alu_zx,
    output logic            alu_nx,
    output logic            alu_zy,
    output logic            alu_ny,
    output logic            alu_f,
    output logic            alu_no,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    output logic [PC_W-1:0] pc,
    output logic            instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    localparam logic [PC_W-1:0] c_PC_INC = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q;
    logic [15:0]     a_q;
    logic [15:0]     d_q;
    logic [15:0]     ir_q;
    logic [15:0]     m_q;
    logic [15:0]     res_q;
    logic            zr_q;
    logic            ng_q;
    logic [PC_W-1:0] pc_q;
    logic            rom_req_q;
    logic            mem_re_q;
    logic            mem_we_q;
    logic            done_q;

    logic [PC_W-1:0] w_pc_inc;
    logic            w_jump;

    assign w_pc_inc = pc_q + c_PC_INC;
    assign w_jump   = (ir_q[2] & ng_q) | (ir_q[1] & zr_q) | (ir_q[0] & ~zr_q & ~ng_q);

    // Handshake strobes are registers, so an ack is honoured only while our own
    // request is actually visible on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            a_q       <= '0;
            d_q       <= '0;
            ir_q      <= '0;
            m_q       <= '0;
            res_q     <= '0;
            zr_q      <= 1'b0;
            ng_q      <= 1'b0;
            pc_q      <= RESET_PC;
            rom_req_q <= 1'b0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    rom_req_q <= 1'b1;
                    if (rom_req_q && rom_ack) begin
                        ir_q      <= rom_rdata;
                        rom_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!ir_q[15]) begin
                        a_q       <= {1'b0, ir_q[14:0]};
                        pc_q      <= w_pc_inc;
                        done_q    <= 1'b1;
                        rom_req_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end else if (ir_q[12]) begin
                        mem_re_q <= 1'b1;
                        state_q  <= S_READ;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_READ: begin
                    if (mem_re_q && mem_ack) begin
                        m_q      <= mem_rdata;
                        mem_re_q <= 1'b0;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q <= alu_out;
                    zr_q  <= alu_zr;
                    ng_q  <= alu_ng;
                    if (ir_q[3]) begin
                        mem_we_q <= 1'b1;
                        state_q  <= S_WRITE;
                    end else begin
                        state_q <= S_COMMIT;
                    end
                end
                S_WRITE: begin
                    if (mem_we_q && mem_ack) begin
                        mem_we_q <= 1'b0;
                        state_q  <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // Jump target is the A value from before this instruction's own A write.
                    pc_q <= w_jump ? a_q[PC_W-1:0] : w_pc_inc;
                    if (ir_q[5]) begin
                        a_q <= res_q;
                    end
                    if (ir_q[4]) begin
                        d_q <= res_q;
                    end
                    done_q    <= 1'b1;
                    rom_req_q <= 1'b1;
                    state_q   <= S_FETCH;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    assign rom_req    = rom_req_q;
    assign rom_addr   = pc_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = a_q[PC_W-1:0];
    assign mem_wdata  = res_q;
    assign alu_x      = d_q;
    assign alu_y      = ir_q[12] ? m_q : a_q;
    assign alu_zx     = ir_q[11];
    assign alu_nx     = ir_q[10];
    assign alu_zy     = ir_q[9];
    assign alu_ny     = ir_q[8];
    assign alu_f      = ir_q[7];
    assign alu_no     = ir_q[6];
    assign pc         = pc_q;
    assign instr_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hack_cpu_seq
//  Description : Directed program for hack_cpu_seq with ROM/RAM/ALU models and
//                a queue-based retire and memory-transaction scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_seq;

    logic        clk;
    logic        rst_n;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic [15:0] rom_rdata;
    logic        rom_ack;
    logic        mem_re;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [14:0] pc;
    logic        instr_done;

    hack_cpu_seq #(.PC_W(15), .RESET_PC(15'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .rom_ack(rom_ack),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc), .instr_done(instr_done)
    );

    typedef struct {
        logic [14:0] pc;
        logic [15:0] d;
        logic [15:0] y;
        logic [5:0]  ctrl;
        int          cyc;
    } ret_t;

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [15:0] data;
    } mem_t;

    ret_t        ret_q[$];
    mem_t        mem_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] rom_mem [0:32767];
    logic [15:0] ram_mem [0:32767];
    int          rom_cnt;
    int          mem_cnt;
    int          mon_cyc;
    int          mon_last;
    logic        rw_p, mw_p;
    logic [14:0] ra_p, ma_p;
    logic [15:0] md_p;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hack ALU reference, driven purely from the sequencer's outputs.
    always_comb begin
        logic [15:0] x, y, o;
        x = alu_x;
        if (alu_zx) x = 16'h0000;
        if (alu_nx) x = ~x;
        y = alu_y;
        if (alu_zy) y = 16'h0000;
        if (alu_ny) y = ~y;
        o = alu_f ? (x + y) : (x & y);
        if (alu_no) o = ~o;
        alu_out = o;
        alu_zr  = (o == 16'h0000);
        alu_ng  = o[15];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ret(input logic [15:0] instr, input logic [14:0] epc,
                            input logic [15:0] ed, input logic [15:0] ey, input int ecyc);
        ret_t e;
        e.pc   = epc;
        e.d    = ed;
        e.y    = ey;
        e.ctrl = instr[11:6];
        e.cyc  = ecyc;
        ret_q.push_back(e);
    endtask

    task automatic push_mem(input logic we, input logic [14:0] addr, input logic [15:0] data);
        mem_t m;
        m.we   = we;
        m.addr = addr;
        m.data = data;
        mem_q.push_back(m);
    endtask

    // ROM: address 30 answers after 3 wait cycles, all others immediately.
    // RAM: reads answer immediately, writes after 2 wait cycles.
    initial begin
        rom_ack = 1'b0; rom_rdata = 16'hDEAD; rom_cnt = 0;
        mem_ack = 1'b0; mem_rdata = 16'hBEEF; mem_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rom_req) begin
                if (rom_cnt >= ((rom_addr == 15'd30) ? 3 : 0)) begin
                    rom_ack = 1'b1; rom_rdata = rom_mem[rom_addr]; rom_cnt = 0;
                end else begin
                    rom_ack = 1'b0; rom_rdata = 16'hDEAD; rom_cnt++;
                end
            end else begin
                rom_ack = 1'b0; rom_rdata = 16'hDEAD; rom_cnt = 0;
            end
            if (mem_re || mem_we) begin
                if (mem_cnt >= (mem_we ? 2 : 0)) begin
                    mem_ack = 1'b1;
                    if (mem_we) ram_mem[mem_addr] = mem_wdata;
                    else        mem_rdata = ram_mem[mem_addr];
                    mem_cnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_cnt++;
                end
            end else begin
                mem_ack = 1'b0; mem_cnt = 0;
            end
        end
    end

    // Monitor: pops expectations on retire pulses and completed memory handshakes.
    initial begin
        ret_t e;
        mem_t m;
        mon_cyc = 0; mon_last = 0; rw_p = 1'b0; mw_p = 1'b0;
        ra_p = '0; ma_p = '0; md_p = '0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (mem_re && mem_we) check("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
            if (rst_n && rw_p) begin
                check("rom_req_hold", 32'(rom_req), 32'd1);
                check("rom_addr_hold", 32'(rom_addr), 32'(ra_p));
            end
            if (rst_n && mw_p) begin
                check("mem_we_hold", 32'(mem_we), 32'd1);
                check("mem_addr_hold", 32'(mem_addr), 32'(ma_p));
                check("mem_wdata_hold", 32'(mem_wdata), 32'(md_p));
            end
            rw_p = rst_n && rom_req && !rom_ack;
            mw_p = rst_n && mem_we && !mem_ack;
            ra_p = rom_addr; ma_p = mem_addr; md_p = mem_wdata;
            if (instr_done) begin
                if (ret_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL retire_unexpected: got retire at pc=%0h expected none", pc);
                end else begin
                    e = ret_q.pop_front();
                    check("retire_pc", 32'(pc), 32'(e.pc));
                    check("retire_D", 32'(alu_x), 32'(e.d));
                    check("retire_alu_y", 32'(alu_y), 32'(e.y));
                    check("retire_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'(e.ctrl));
                    if (e.cyc != 0) check("retire_latency", 32'(mon_cyc - mon_last), 32'(e.cyc));
                end
                mon_last = mon_cyc;
            end
            if ((mem_re || mem_we) && mem_ack) begin
                if (mem_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_unexpected: got we=%0b addr=%0h expected none", mem_we, mem_addr);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_kind_we", 32'(mem_we), 32'(m.we));
                    check("mem_addr", 32'(mem_addr), 32'(m.addr));
                    if (m.we) check("mem_wdata", 32'(mem_wdata), 32'(m.data));
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            rom_mem[i] = 16'h0000;
            ram_mem[i] = 16'h0000;
        end
        rom_mem[0]     = 16'h0005;  // @5
        rom_mem[1]     = 16'hEC10;  // D=A
        rom_mem[2]     = 16'h0007;  // @7
        rom_mem[3]     = 16'hE7C8;  // M=D+1
        rom_mem[4]     = 16'hFDC8;  // M=M+1
        rom_mem[5]     = 16'hEA90;  // D=0
        rom_mem[6]     = 16'h0014;  // @20
        rom_mem[7]     = 16'hEA82;  // 0;JEQ
        rom_mem[20]    = 16'hEA81;  // 0;JGT
        rom_mem[21]    = 16'h001E;  // @30
        rom_mem[22]    = 16'hEAA2;  // A=0;JEQ
        rom_mem[30]    = 16'h0009;  // @9 (slow ROM)
        rom_mem[31]    = 16'hEE90;  // D=-1
        rom_mem[32]    = 16'hE304;  // D;JLT
        rom_mem[9]     = 16'h7FFF;  // @32767
        rom_mem[10]    = 16'hEA87;  // 0;JMP
        rom_mem[32767] = 16'h000B;  // @11, pc wraps

        push_ret(16'h0005, 15'd1,     16'h0000, 16'd5,  0);
        push_ret(16'hEC10, 15'd2,     16'h0005, 16'd5,  4);
        push_ret(16'h0007, 15'd3,     16'h0005, 16'd7,  2);
        push_mem(1'b1, 15'd7, 16'd6);
        push_ret(16'hE7C8, 15'd4,     16'h0005, 16'd7,  7);
        push_mem(1'b0, 15'd7, 16'd0);
        push_mem(1'b1, 15'd7, 16'd7);
        push_ret(16'hFDC8, 15'd5,     16'h0005, 16'd6,  8);
        push_ret(16'hEA90, 15'd6,     16'h0000, 16'd7,  4);
        push_ret(16'h0014, 15'd7,     16'h0000, 16'd20, 2);
        push_ret(16'hEA82, 15'd20,    16'h0000, 16'd20, 4);
        push_ret(16'hEA81, 15'd21,    16'h0000, 16'd20, 4);
        push_ret(16'h001E, 15'd22,    16'h0000, 16'd30, 2);
        push_ret(16'hEAA2, 15'd30,    16'h0000, 16'd0,  4);
        push_ret(16'h0009, 15'd31,    16'h0000, 16'd9,  5);
        push_ret(16'hEE90, 15'd32,    16'hFFFF, 16'd9,  4);
        push_ret(16'hE304, 15'd9,     16'hFFFF, 16'd9,  4);
        push_ret(16'h7FFF, 15'd10,    16'hFFFF, 16'd6,  2);
        push_ret(16'hEA87, 15'h7FFF,  16'hFFFF, 16'h7FFF, 4);
        push_ret(16'h000B, 15'd0,     16'hFFFF, 16'd11, 2);
        push_ret(16'h0005, 15'd1,     16'hFFFF, 16'd5,  2);
        push_ret(16'hEC10, 15'd2,     16'h0005, 16'd5,  4);
        push_ret(16'h0007, 15'd3,     16'h0005, 16'd7,  2);

        repeat (2) @(posedge clk);
        #1;
        check("reset_rom_req", 32'(rom_req), 32'd0);
        check("reset_mem_re", 32'(mem_re), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_done", 32'(instr_done), 32'd0);
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_D", 32'(alu_x), 32'd0);
        check("reset_A", 32'(alu_y), 32'd0);
        check("reset_wdata", 32'(mem_wdata), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_rom_req", 32'(rom_req), 32'd1);
        check("first_rom_addr", 32'(rom_addr), 32'd0);

        n = 0;
        while ((ret_q.size() != 0 || mem_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d retires pending expected 0", ret_q.size());
        end

        n = 0;
        while (!mem_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("write_reached", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midwrite_mem_we", 32'(mem_we), 32'd0);
        check("midwrite_rom_req", 32'(rom_req), 32'd0);
        check("midwrite_pc", 32'(pc), 32'd0);
        check("midwrite_D", 32'(alu_x), 32'd0);
        check("midwrite_A", 32'(alu_y), 32'd0);
        check("midwrite_mem_addr", 32'(mem_addr), 32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_rom_req", 32'(rom_req), 32'd1);
        check("restart_rom_addr", 32'(rom_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
